// File: rtl/i2c_pkg.sv
// Shared widths, state encoding and helpers for the write-only I2C slave receiver.
package i2c_pkg;
    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned I2C_CNT_W  = 4;

    localparam logic [I2C_CNT_W-1:0] I2C_BITS = I2C_CNT_W'(8);
    localparam logic [I2C_CNT_W-1:0] I2C_LAST = I2C_CNT_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_t;

    // Bit counter stops at a full byte so it can never wrap between ACK phases.
    function automatic logic [I2C_CNT_W-1:0] cnt_inc(input logic [I2C_CNT_W-1:0] c);
        return (c >= I2C_BITS) ? I2C_BITS : c + I2C_CNT_W'(1);
    endfunction
endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and emits registered SCL edge and START/STOP pulses.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_h;
    logic                   sda_h;
    logic                   scl_c;
    logic                   sda_c;
    logic                   start_c;
    logic                   stop_c;

    assign scl_c   = scl_ff[SYNC_STAGES-1];
    assign sda_c   = sda_ff[SYNC_STAGES-1];
    assign start_c = scl_c & scl_h & sda_h & ~sda_c;
    assign stop_c  = scl_c & scl_h & ~sda_h & sda_c;

    // Bus conditions outrank clock edges seen in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_ff    <= '1;
            sda_ff    <= '1;
            scl_h     <= 1'b1;
            sda_h     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            scl_ff    <= {scl_ff[SYNC_STAGES-2:0], scl};
            sda_ff    <= {sda_ff[SYNC_STAGES-2:0], sda_in};
            scl_h     <= scl_c;
            sda_h     <= sda_c;
            start_det <= start_c;
            stop_det  <= stop_c;
            scl_rise  <= scl_c & ~scl_h & ~(start_c | stop_c);
            scl_fall  <= ~scl_c & scl_h & ~(start_c | stop_c);
            sda_s     <= sda_c;
        end
    end
endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: address match, byte reception, open-drain ACK generation.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_pull,
    output logic [I2C_BYTE_W-1:0] data_out,
    output logic                  data_valid,
    output logic                  addr_match,
    output logic                  busy
);
    i2c_state_t            state;
    logic [I2C_BYTE_W-1:0] shift;
    logic [I2C_CNT_W-1:0]  cnt;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_det;
    logic                  stop_det;
    logic                  sda_s;
    logic [I2C_BYTE_W-1:0] shift_nxt;
    logic                  byte_done;
    logic                  addr_ok;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign shift_nxt = {shift[I2C_BYTE_W-2:0], sda_s};
    assign byte_done = scl_fall && (cnt == I2C_BITS);
    // Only writes are supported, so R/W=1 is treated like a foreign address.
    assign addr_ok   = (shift[I2C_BYTE_W-1:1] == SLAVE_ADDR) && !shift[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift      <= '0;
            cnt        <= '0;
            sda_pull   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (stop_det) begin
                state      <= IDLE;
                cnt        <= '0;
                sda_pull   <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b0;
            end else if (start_det) begin
                state      <= ADDR;
                cnt        <= '0;
                sda_pull   <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= shift_nxt;
                            cnt   <= cnt_inc(cnt);
                        end else if (byte_done) begin
                            if (addr_ok) begin
                                state      <= ADDR_ACK;
                                sda_pull   <= 1'b1;
                                addr_match <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    // The ACK slot ends at the SCL fall after the 9th clock.
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            state    <= DATA;
                            sda_pull <= 1'b0;
                            cnt      <= '0;
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift <= shift_nxt;
                            cnt   <= cnt_inc(cnt);
                            if (cnt == I2C_LAST) begin
                                data_out   <= shift_nxt;
                                data_valid <= 1'b1;
                            end
                        end else if (byte_done) begin
                            state    <= DATA_ACK;
                            sda_pull <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench: bit-level I2C master plus a transaction-level model of the slave.
module tb_i2c_slave_rx;
    localparam logic [6:0] SLAVE = 7'h50;
    localparam int         Q     = 6;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       scl     = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_in;
    logic       sda_pull;
    logic [7:0] data_out;
    logic       data_valid;
    logic       addr_match;
    logic       busy;

    assign sda_in = sda_drv & ~sda_pull;

    i2c_slave_rx #(.SLAVE_ADDR(SLAVE), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda_in     (sda_in),
        .sda_pull   (sda_pull),
        .data_out   (data_out),
        .data_valid (data_valid),
        .addr_match (addr_match),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model state, written only by the stimulus process.
    bit          m_busy, m_match, m_sel, m_pull, m_hold;
    logic [7:0]  exp_mem [64];
    int          wr_idx;
    bit          chk_req, lit_req;
    string       chk_name, lit_name;
    logic [31:0] lit_act, lit_exp;

    // Counters, written only by the compare process.
    int          n_cmp, n_bad, n_pulse, rd_idx;
    bit          dv_prev;

    always @(negedge clk) begin
        if (reset && data_valid) begin
            n_cmp++;
            n_pulse++;
            if (rd_idx >= wr_idx) begin
                n_bad++;
                $display("FAIL dv_unexpected: data_out=%02h pulsed, no byte expected", data_out);
            end else begin
                if (data_out !== exp_mem[rd_idx]) begin
                    n_bad++;
                    $display("FAIL dv_data: got %02h, expected %02h", data_out, exp_mem[rd_idx]);
                end
                rd_idx++;
            end
        end
        if (dv_prev) begin
            n_cmp++;
            if (data_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL dv_width: data_valid=%b one clk after pulse, expected 0", data_valid);
            end
        end
        dv_prev = data_valid;
        if (m_hold) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL busy_hold: got %b, expected 1", busy);
            end
        end
        if (chk_req) begin
            n_cmp += 3;
            if (busy !== m_busy) begin
                n_bad++;
                $display("FAIL %s busy: got %b, expected %b", chk_name, busy, m_busy);
            end
            if (addr_match !== m_match) begin
                n_bad++;
                $display("FAIL %s addr_match: got %b, expected %b", chk_name, addr_match, m_match);
            end
            if (sda_pull !== m_pull) begin
                n_bad++;
                $display("FAIL %s sda_pull: got %b, expected %b", chk_name, sda_pull, m_pull);
            end
        end
        if (lit_req) begin
            n_cmp++;
            if (lit_act !== lit_exp) begin
                n_bad++;
                $display("FAIL %s: got %0h, expected %0h", lit_name, lit_act, lit_exp);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic sample(input string name, input bit pull);
        chk_name = name;
        m_pull   = pull;
        chk_req  = 1'b1;
        clks(1);
        chk_req  = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_req  = 1'b1;
        clks(1);
        lit_req  = 1'b0;
    endtask

    task automatic put_bit(input string name, input bit b, input bit exp_pull);
        sda_drv = b;
        clks(Q);
        scl = 1'b1;
        clks(Q + 2);
        sample(name, exp_pull);
        clks(Q - 3);
        scl = 1'b0;
        clks(Q);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        clks(Q);
        scl = 1'b1;
        clks(Q);
        sda_drv = 1'b0;
        clks(Q);
        m_busy  = 1'b1;
        m_match = 1'b0;
        m_sel   = 1'b0;
        sample("start", 1'b0);
        clks(Q - 1);
        scl = 1'b0;
        clks(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        clks(Q);
        scl = 1'b1;
        clks(Q);
        sda_drv = 1'b1;
        clks(Q);
        m_busy  = 1'b0;
        m_match = 1'b0;
        m_sel   = 1'b0;
        sample("stop", 1'b0);
        clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_addr);
        if (!is_addr && m_sel) begin
            exp_mem[wr_idx] = b;
            wr_idx++;
        end
        for (int i = 7; i >= 0; i--)
            put_bit(is_addr ? "addr_bit" : "data_bit", b[i], 1'b0);
        if (is_addr) begin
            m_sel   = (b[7:1] == SLAVE) && !b[0];
            m_match = m_sel;
        end
        put_bit(is_addr ? "addr_ack" : "data_ack", 1'b1, m_sel);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++)
            put_bit("part_bit", b[7-i], 1'b0);
    endtask

    int p0;

    initial begin
        clks(3);
        lit("rst_busy", 32'(busy), 0);
        lit("rst_pull", 32'(sda_pull), 0);
        lit("rst_match", 32'(addr_match), 0);
        lit("rst_valid", 32'(data_valid), 0);
        lit("rst_dout", 32'(data_out), 32'h00);
        reset = 1'b1;
        clks(4);
        sample("idle", 1'b0);

        // Addressed write of one byte.
        p0 = n_pulse;
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h3C, 1'b0);
        i2c_stop();
        lit("s2_dout", 32'(data_out), 32'h3C);
        lit("s2_pulses", 32'(n_pulse - p0), 1);

        // Reset pulled mid-address clears everything asynchronously.
        i2c_start();
        send_bits(8'hA0, 3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        lit("arst_busy", 32'(busy), 0);
        lit("arst_dout", 32'(data_out), 32'h00);
        lit("arst_pull", 32'(sda_pull), 0);
        m_busy = 1'b0; m_match = 1'b0; m_sel = 1'b0;
        scl = 1'b1;
        sda_drv = 1'b1;
        clks(4);
        reset = 1'b1;
        clks(4);
        sample("post_rst", 1'b0);
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h99, 1'b0);
        i2c_stop();
        lit("s1_dout", 32'(data_out), 32'h99);

        // Foreign address: no ACK, nothing latched.
        p0 = n_pulse;
        i2c_start();
        send_byte(8'hA2, 1'b1);
        send_byte(8'h77, 1'b0);
        i2c_stop();
        lit("s3_pulses", 32'(n_pulse - p0), 0);
        lit("s3_dout", 32'(data_out), 32'h99);

        // Read request is NACKed and ignored.
        p0 = n_pulse;
        i2c_start();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h5A, 1'b0);
        i2c_stop();
        lit("s4_pulses", 32'(n_pulse - p0), 0);

        // Three bytes in one transfer.
        p0 = n_pulse;
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'hFF, 1'b0);
        i2c_stop();
        lit("s5_pulses", 32'(n_pulse - p0), 3);
        lit("s5_dout", 32'(data_out), 32'hFF);

        // STOP inside the third byte discards it.
        p0 = n_pulse;
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h80, 1'b0);
        send_bits(8'hFF, 4);
        i2c_stop();
        lit("s5b_pulses", 32'(n_pulse - p0), 2);
        lit("s5b_dout", 32'(data_out), 32'h80);

        // Repeated START between two addressed bytes keeps busy high.
        p0 = n_pulse;
        i2c_start();
        m_hold = 1'b1;
        send_byte(8'hA0, 1'b1);
        send_byte(8'h55, 1'b0);
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'hAA, 1'b0);
        m_hold = 1'b0;
        i2c_stop();
        lit("s6_pulses", 32'(n_pulse - p0), 2);
        lit("s6_dout", 32'(data_out), 32'hAA);

        clks(10);
        lit("all_bytes_seen", 32'(rd_idx), 32'(wr_idx));
        clks(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C slave receiver; sits directly downstream of the I2C master on the same SCL/SDA pair.
- Oversamples the bus with the system clock and detects START and STOP conditions.
- Matches a 7-bit address, ACKs the address and each data byte by pulling SDA low, and presents each received byte with a one-cycle valid strobe.
- Consumer side is a register file / FIFO in the same design.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this slave responds to.
- SYNC_STAGES, 2, synchroniser depth on scl and sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- reset  input  1  asynchronous, active-low reset.
- scl  input  1  bus clock from the master.
- sda_in  input  1  sampled SDA line level.
- sda_pull  output  1  1 = drive SDA low (open-drain ACK); 0 = release.
- data_out  output  8  last received data byte, MSB first on the wire.
- data_valid  output  1  one-clk pulse when data_out updates.
- addr_match  output  1  high from the address ACK until STOP or repeated START.
- busy  output  1  high between START and STOP.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low (port reset).
- Reset values: sda_pull=0, data_out=8'h00, data_valid=0, addr_match=0, busy=0, state=IDLE, bit counter=0, synchroniser flops=1.
- Synchronisation:
  - scl and sda_in each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - All bus events are seen SYNC_STAGES+1 clks after the pin change.
- Event detection, on the synced signals:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - SCL rise and SCL fall: one-clk pulses.
  - START/STOP take priority over SCL edges in the same clk.
- Shift register: 8 bits, shifts sda left on each SCL rise in the ADDR and DATA states. A 4-bit counter counts bits 0..8.
- States and transitions:
  - IDLE: wait for START -> ADDR; busy=1, counter=0.
  - ADDR: on the 8th SCL rise, compare shift[7:1] with SLAVE_ADDR and check shift[0] (R/W).
    - Match and R/W=0 -> ADDR_ACK, taken at the following SCL fall.
    - Any mismatch, or R/W=1 (reads unsupported) -> IGNORE; no ACK (NACK).
  - ADDR_ACK: sda_pull=1 from the SCL fall after bit 8 until the SCL fall after bit 9. addr_match=1 asserted on entry. Then -> DATA, counter=0.
  - DATA: on the 8th SCL rise, latch shift into data_out and pulse data_valid for exactly 1 clk. At the next SCL fall -> DATA_ACK.
  - DATA_ACK: sda_pull behaves as in ADDR_ACK; afterwards -> DATA. Unlimited bytes per transfer.
  - IGNORE: sda_pull=0; wait for STOP or START.
- Global rules:
  - STOP in any state -> IDLE; sda_pull=0, addr_match=0, busy=0, counter cleared.
  - STOP or START inside a partial byte discards that byte, with no data_valid.
  - Repeated START in any non-IDLE state -> ADDR; counter=0, addr_match=0, sda_pull released the same clk, busy stays 1.
  - sda_pull changes only on a synced SCL fall or on reset/STOP/START; never while SCL is high.
  - The slave's own pulled-low SDA during ACK never triggers START, because SCL is low at that moment.
  - Counter saturates at 8; no wrap. Never exceeds 8 between ACK phases.
  - Reset mid-transfer: immediate return to the reset values; the bus is released asynchronously.

Decomposition:
- Shared package i2c_pkg:
  - state encoding constants (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE);
  - I2C_ADDR_W=7, I2C_BYTE_W=8.
- Sub-module i2c_bus_sync: synchroniser plus edge/START/STOP detector. Outputs scl_rise, scl_fall, start_det, stop_det and sda_s.
- The top level holds the FSM, shifter, counter and outputs.

Test Plan:
- Reset low mid-address (after 3 bits), then released -> all outputs 0; a fresh START with addr 0x50 W is accepted normally.
- START, address 0x50+W (byte 8'hA0), data 8'h3C, STOP -> sda_pull high during both 9th clocks; data_out=8'h3C; data_valid is a single 1-clk pulse; busy drops after STOP.
- START, address 0x51+W (byte 8'hA2) -> sda_pull stays 0 throughout, addr_match=0, no data_valid through STOP.
- START, 0x50+R (byte 8'hA1) -> NACK, state IGNORE; a later data byte is not latched.
- START, 0x50+W, 3 bytes 8'h01/8'h80/8'hFF -> three data_valid pulses in order, three ACKs; STOP after byte 2's 4th bit discards it (2 pulses only in that variant).
- START, 0x50+W, byte 8'h55, repeated START, 0x50+W, byte 8'hAA, STOP -> two pulses (8'h55, 8'hAA); addr_match drops for 1 byte window; busy stays high throughout.
